// File: rtl/clk_div_prog.sv
// Programmable clock divider with shadowed period/duty and sync restart.
// Optional period counter enabled by defining CLK_DIV_PERIOD_CNT_EN.
module clk_div_prog #(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 100000000
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] duty_in,
    output logic             clk_out,
    output logic             tick,
    output logic             pending,
    output logic             cfg_err,
    output logic [15:0]      period_cnt
);

    localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_DIV / 2);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_act_q, d_act_d;
    logic [WIDTH-1:0] h_act_q, h_act_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [WIDTH-1:0] h_sh_q, h_sh_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic load_ok;
    logic last;
    logic wrap_en;
    logic apply;

    // Decode the events that drive this cycle's update.
    always_comb begin
        load_ok = load && (div_in >= TWO);
        last    = (cnt_q == (d_act_q - ONE));
        wrap_en = !sync_clr && enable && last;
        apply   = pend_q && (sync_clr || wrap_en);
    end

    // Period counter, divided clock and wrap pulse.
    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (sync_clr) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (enable) begin
            cnt_d  = last ? '0 : (cnt_q + ONE);
            clk_d  = (cnt_q < h_act_q);
            tick_d = last;
        end
    end

    // Active setting takes the shadow value at a boundary.
    always_comb begin
        d_act_d = d_act_q;
        h_act_d = h_act_q;
        if (apply) begin
            d_act_d = d_sh_q;
            h_act_d = h_sh_q;
        end
    end

    // Shadow capture, pending flag and sticky load error.
    always_comb begin
        d_sh_d = d_sh_q;
        h_sh_d = h_sh_q;
        pend_d = pend_q;
        err_d  = err_q;
        if (apply) begin
            pend_d = 1'b0;
        end
        if (load_ok) begin
            d_sh_d = div_in;
            h_sh_d = duty_in;
            pend_d = 1'b1;
            err_d  = 1'b0;
        end else if (load) begin
            err_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            d_act_q <= DEF_D;
            h_act_q <= DEF_H;
            d_sh_q  <= DEF_D;
            h_sh_q  <= DEF_H;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            d_act_q <= d_act_d;
            h_act_q <= h_act_d;
            d_sh_q  <= d_sh_d;
            h_sh_q  <= h_sh_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

`ifdef CLK_DIV_PERIOD_CNT_EN
    logic [15:0] pcnt_q, pcnt_d;

    // Completed-period count, cleared by a synchronous restart.
    always_comb begin
        pcnt_d = pcnt_q;
        if (sync_clr) begin
            pcnt_d = '0;
        end else if (wrap_en) begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    // Period count register.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_cnt = pcnt_q;
`else
    assign period_cnt = 16'd0;
`endif

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pend_q;
    assign cfg_err = err_q;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 28: width of the period counter, divisor and duty values.
REQ-002 Parameter DEFAULT_DIV, default 100000000: divisor active after reset.
REQ-003 clock_in  input  1  system clock; every register updates on its rising edge.
REQ-004 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 enable  input  1  high: counter advances; low: counter and outputs freeze, with tick forced to 0.
REQ-006 sync_clr  input  1  synchronous restart of the period.
REQ-007 load  input  1  single-cycle strobe that captures div_in and duty_in.
REQ-008 div_in  input  WIDTH  requested period in clock_in cycles.
REQ-009 duty_in  input  WIDTH  requested high-time in clock_in cycles.
REQ-010 clk_out  output  1  registered divided clock.
REQ-011 tick  output  1  one-cycle pulse marking each period wrap.
REQ-012 pending  output  1  a captured setting is waiting for a period boundary.
REQ-013 cfg_err  output  1  sticky flag for a rejected load.
REQ-014 period_cnt  output  16  count of completed periods.

Function
REQ-015 Active registers D_act and H_act and a WIDTH-bit counter cnt SHALL govern the output, with cnt sweeping 0..D_act-1.
REQ-016 On each enabled cycle: if cnt==D_act-1 then cnt<=0 and tick<=1, otherwise cnt<=cnt+1 and tick<=0.
REQ-017 On each enabled cycle, clk_out SHALL be set to (cnt<H_act) using the pre-update cnt, giving a fixed one-cycle lag.
REQ-018 The resulting high-time SHALL be min(H_act,D_act) cycles per period: H_act=0 gives constant low; H_act>=D_act gives constant high.
REQ-019 load with div_in>=2 SHALL write shadow registers D_sh<=div_in and H_sh<=duty_in, set pending<=1 and clear cfg_err.
REQ-020 load with div_in<2 SHALL leave shadow registers and pending unchanged and set cfg_err<=1.
REQ-021 cfg_err SHALL stay set until the next valid load.
REQ-022 A load while pending=1 SHALL overwrite the shadow registers; only the last valid load takes effect.
REQ-023 At a wrap with pending=1: D_act<=D_sh, H_act<=H_sh, pending<=0, so the new setting governs the period starting at cnt=0.
REQ-024 A load in the same cycle as a wrap SHALL miss that wrap and be applied at the following wrap.
REQ-025 sync_clr=1 SHALL force cnt<=0, tick<=0 and clk_out<=0, and SHALL apply any pending setting immediately, regardless of enable.
REQ-026 sync_clr SHALL have priority over a load in the same cycle; the load is then handled as in REQ-019/020 without being applied this cycle.
REQ-027 With enable=0, load SHALL still be captured and pending SHALL still set.

Reset
REQ-028 While reset_n=0: cnt=0, D_act=DEFAULT_DIV, H_act=DEFAULT_DIV/2, D_sh=DEFAULT_DIV, H_sh=DEFAULT_DIV/2, pending=0, cfg_err=0, clk_out=0, tick=0, period_cnt=0.
REQ-029 Reset asserted mid-period SHALL abort the period, with outputs at reset values immediately, independent of clock_in.
REQ-030 After reset deassertion, the first enabled edge SHALL start at cnt=0.

Configuration
REQ-031 With macro CLK_DIV_PERIOD_CNT_EN defined, period_cnt SHALL increment by 1 on each enabled wrap, wrapping 0xFFFF->0, and SHALL clear on sync_clr.
REQ-032 Without CLK_DIV_PERIOD_CNT_EN, period_cnt SHALL be tied to 0, the port SHALL remain present, and no counter logic SHALL be inferred.

Verification
REQ-033 DEFAULT_DIV=10, enable=1 after reset -> clk_out 5 high/5 low repeating, and tick every 10 cycles when cnt goes 9->0.
REQ-034 load with div_in=4, duty_in=1 mid-period -> pending=1; the current 10-cycle period completes; then 1 high/3 low; pending=0 at the wrap.
REQ-035 load with div_in=1 -> cfg_err=1 and the period is unchanged; a later load with div_in=6, duty_in=3 -> cfg_err=0 and a 3/3 output.
REQ-036 enable low for 7 cycles mid-period -> cnt and clk_out hold, tick=0; resuming continues the same period with no extra tick.
REQ-037 duty_in=0 then duty_in=8 with div_in=8 -> constant low, then constant high; sync_clr with a setting pending -> the new setting is active on the next cycle and cnt=0.
REQ-038 With CLK_DIV_PERIOD_CNT_EN and div_in=2, run 65537 periods -> period_cnt=1; reset_n pulsed low mid-period -> all outputs 0 asynchronously.
